// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction at a time and drives a single-outstanding,
// ack-based data port with byte enables. It returns extended load data or a fault cause.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // The counter only needs to reach TIMEOUT_CYCLES-1 before the limit fires.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    size_q, size_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_fault_q, resp_fault_d;
    logic [1:0]    resp_cause_q, resp_cause_d;

    logic        accepted;
    logic        illegal;
    logic        misaligned;
    logic        req_fault;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    assign accepted    = req_valid & (req_is_load | req_is_store);
    assign illegal     = (req_is_load & req_is_store) | (req_size == 3'b011)
                       | (req_size[2:1] == 2'b11) | (req_is_store & req_size[2]);
    assign misaligned  = ((req_size[1:0] == 2'b01) & req_addr[0])
                       | ((req_size[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    assign req_fault   = illegal | misaligned;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Gated by rst so every output reads 0 while reset is held.
    assign stall = ~rst & (((state_q == IDLE) & accepted & ~req_fault) | (state_q == ACCESS));

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        lane_be    = 4'b1111;
        lane_wdata = req_wdata;
        case (req_size[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_data = {24'd0, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        off_d        = off_q;
        size_d       = size_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_cause_d = resp_cause_q;

        case (state_q)
            IDLE: begin
                if (accepted && req_fault) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                    resp_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                    resp_rdata_d = 32'd0;
                end else if (accepted) begin
                    state_d     = ACCESS;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_is_store;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_be_d    = lane_be;
                    mem_wdata_d = lane_wdata;
                    off_d       = req_addr[1:0];
                    size_d      = req_size;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_cause_d = CAUSE_NONE;
                    resp_rdata_d = mem_we_q ? 32'd0 : load_data;
                end else if (timeout_hit) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                    resp_cause_d = CAUSE_TIMEOUT;
                    resp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            off_q        <= 2'd0;
            size_q       <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= 1'b0;
            resp_cause_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            off_q        <= off_d;
            size_q       <= size_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_cause_q <= resp_cause_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign resp_cause = resp_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for loads, stores, faults,
// timeout and reset during an access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_load, req_is_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .resp_cause(resp_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Transaction record observed by run_txn.
    int          n_req, n_stall, t_resp;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_we, o_fault;
    logic [1:0]  o_cause;

    // Presents a request in cycle 0, acks on the ack_at-th mem_req cycle (0 = never),
    // and records mem_* at the first mem_req cycle plus the completion.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata);
        n_req = 0; n_stall = 0; t_resp = -1;
        o_addr = 'x; o_wdata = 'x; o_be = 'x; o_we = 'x;
        o_rdata = 'x; o_fault = 'x; o_cause = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_is_load = ld; req_is_store = st;
        req_size = size; req_addr = addr; req_wdata = wdata;
        #1;
        if (stall) n_stall++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
            mem_ack = 1'b0; mem_rdata = 32'h0;
            #1;
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
                end
                if (ack_at != 0 && n_req == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
            end
            if (stall) n_stall++;
            if (resp_valid) begin
                t_resp = c; o_rdata = resp_rdata; o_fault = resp_fault; o_cause = resp_cause;
                break;
            end
        end
        check("resp_seen", 32'(t_resp != -1), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_size = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", {mem_req, mem_we, mem_be, stall, resp_valid, resp_fault, resp_cause},
              32'd0);
        check("rst_data", mem_addr | mem_wdata | resp_rdata, 32'd0);
        rst = 1'b0;

        // LW 0x100, ack on third mem_req cycle
        run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("lw_be", o_be, 4'b1111);
        check("lw_addr", o_addr, 32'h100);
        check("lw_we", o_we, 1'b0);
        check("lw_req_cycles", n_req, 3);
        check("lw_stall_cycles", n_stall, 4);
        check("lw_resp_cycle", t_resp, 4);
        check("lw_rdata", o_rdata, 32'hDEADBEEF);
        check("lw_fault_cause", {o_fault, o_cause}, 3'b000);
        @(negedge clk); #1;
        check("lw_pulse_len", resp_valid, 1'b0);
        check("lw_rdata_hold", resp_rdata, 32'hDEADBEEF);

        run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456);
        check("lb_be", o_be, 4'b1000);
        check("lb_rdata", o_rdata, 32'hFFFFFF80);
        run_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80123456);
        check("lbu_rdata", o_rdata, 32'h00000080);
        run_txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80123456);
        check("lh_be", o_be, 4'b1100);
        check("lh_rdata", o_rdata, 32'hFFFF8012);
        run_txn(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h80129876);
        check("lhu_rdata", o_rdata, 32'h00009876);

        run_txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 1, 32'hFFFFFFFF);
        check("sb_we", o_we, 1'b1);
        check("sb_addr", o_addr, 32'h200);
        check("sb_be", o_be, 4'b0010);
        check("sb_wdata", o_wdata, 32'hA5A5A5A5);
        check("sb_rdata", o_rdata, 32'h0);
        check("sb_resp_cycle", t_resp, 2);
        run_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 1, 32'h0);
        check("sh_be", o_be, 4'b1100);
        check("sh_wdata", o_wdata, 32'hBEEFBEEF);

        run_txn(1'b0, 1'b1, 3'b010, 32'h202, 32'h11111111, 1, 32'h0);
        check("sw_mis_req", n_req, 0);
        check("sw_mis_stall", n_stall, 0);
        check("sw_mis_resp_cycle", t_resp, 1);
        check("sw_mis_fault_cause", {o_fault, o_cause}, 3'b101);
        run_txn(1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 1, 32'h0);
        check("sbu_illegal", {o_fault, o_cause}, 3'b110);
        run_txn(1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 1, 32'h0);
        check("both_illegal", {o_fault, o_cause}, 3'b110);
        run_txn(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0);
        check("lh_misaligned", {o_fault, o_cause, 29'd0}, {3'b101, 29'd0});

        // Neither flag set, plus a stray ack in IDLE: nothing may happen.
        @(negedge clk);
        req_valid = 1'b1; req_size = 3'b010; req_addr = 32'h40; mem_ack = 1'b1;
        #1;
        check("noflag_stall", stall, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_ack = 1'b0;
            #1;
            check("noflag_quiet", {mem_req, resp_valid, stall}, 3'b000);
        end

        run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        check("to_req_cycles", n_req, 4);
        check("to_resp_cycle", t_resp, 5);
        check("to_fault_cause", {o_fault, o_cause}, 3'b111);

        // Reset while the access is outstanding.
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b1; req_size = 3'b010; req_addr = 32'h400;
        @(negedge clk);
        req_valid = 1'b0; req_is_load = 1'b0;
        #1;
        check("rst_mid_prereq", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_drop", {mem_req, stall, resp_valid}, 3'b000);
        repeat (2) begin
            @(negedge clk); #1;
            check("rst_mid_nopulse", {mem_req, resp_valid}, 2'b00);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_after", {mem_req, resp_valid}, 2'b00);

        run_txn(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1, 32'h12345678);
        check("post_rst_addr", o_addr, 32'h0);
        check("post_rst_rdata", o_rdata, 32'h12345678);
        check("post_rst_resp_cycle", t_resp, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/decoder stage and data memory: takes the effective address from the ALU result, store data from the register file and the access size from the decoder.
- Drives a single-outstanding, ack-based data-memory port with byte enables.
- Returns sign- or zero-extended load data for write-back.
- Stalls the pc stage while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of mem_req cycles without mem_ack before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  memory instruction presented this cycle
- req_is_load  in  1  load request
- req_is_store  in  1  store request
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold pc/fetch
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and faults)
- resp_fault  out  1  completion is a fault
- resp_cause  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout
- mem_req  out  1  memory request
- mem_we  out  1  write
- mem_addr  out  32  word address: {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory accepted/completed access
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset: state IDLE, timeout counter 0, all outputs 0. Reset mid-transaction drops mem_req immediately; no resp_valid is produced for the dropped access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, request acceptance:
  - A request is accepted when req_valid and exactly one of req_is_load/req_is_store is high.
  - req_valid with neither flag set is ignored.
  - req_valid with both flags set is accepted as an illegal fault.
- IDLE, checks on an accepted request:
  - Illegal: req_size is 011, 110 or 111; req_size is 100 or 101 on a store; or both load and store set.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal takes priority over misaligned.
- IDLE, outcome:
  - Fault: go to DONE with the cause latched; no memory access.
  - Otherwise: latch mem_addr, mem_we, mem_be and mem_wdata; go to ACCESS.
- Store lanes:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=0011 (addr[1]=0) or 1100.
  - SW: mem_wdata=wdata, mem_be=1111.
- Loads drive mem_be with the same lane pattern and mem_we=0.
- ACCESS:
  - mem_req=1; mem_addr/we/be/wdata held stable until the cycle mem_ack is sampled high.
  - On mem_ack: for loads, extract the lane selected by the latched addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU) into resp_rdata; go to DONE.
  - The timeout counter increments each ACCESS cycle without ack. On reaching TIMEOUT_CYCLES: deassert mem_req, cause=11, go to DONE.
- DONE: resp_valid=1 for exactly one cycle, with resp_fault and resp_cause valid; return to IDLE. resp_rdata holds until the next completion.
- All mem_* and resp_* outputs are registered.
- stall is combinational: (IDLE & accepted & no fault) | ACCESS. It is 0 in DONE so the pc advances with the completion. A faulting request produces no stall cycle.
- Latency: accept in cycle 0, mem_req in cycle 1, mem_ack in cycle k ≥ 1, resp_valid in cycle k+1. A fault gives resp_valid in cycle 1.
- In ACCESS and DONE, req_* inputs are ignored. A new request may be accepted in the cycle after DONE.
- mem_ack outside ACCESS is ignored.

Test Plan:
- LW addr 0x100; memory acks 3 cycles after mem_req with rdata 0xDEADBEEF -> mem_be=1111, stall high 4 cycles, resp_valid one cycle later with resp_rdata=0xDEADBEEF, cause 00.
- LB and LBU at addr 0x103 with rdata 0x80123456 -> mem_be=1000; resp_rdata 0xFFFFFF80 for LB, 0x00000080 for LBU. LH at addr 0x102 -> 0xFFFF8012.
- SB wdata 0x000000A5 at addr 0x201 -> mem_we=1, mem_addr=0x200, mem_be=0010, mem_wdata=0xA5A5A5A5; resp_rdata=0.
- SW at addr 0x202 -> no mem_req, resp_valid next cycle, fault=1, cause=01. Store with size 100 -> cause=10. req_valid with no load/store flag -> nothing happens.
- TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then resp_valid with cause=11.
- Assert rst while in ACCESS -> mem_req, stall and resp_valid go 0 immediately with no completion pulse. After release, LW at addr 0x0 completes normally.
